// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable clock dividers sharing one input clock.
// Each channel produces either a one-cycle tick every N clocks or a square wave of
// period 2N. Divisor writes land in a shadow register and move to the active
// divisor only at a period boundary (or immediately while the channel is
// disabled), so an enabled channel never produces a runt or stretched period.
module clk_div_multi #(
  parameter int NCH     = 2,
  parameter int WIDTH   = 14,
  parameter int DEF_DIV = 12500
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   mode,
  input  logic             sync_clr,
  input  logic [NCH-1:0]   div_wr,
  input  logic [WIDTH-1:0] div_wdata,
  output logic [NCH-1:0]   div_out,
  output logic [NCH-1:0]   div_pend
);

  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);

  // A divisor of zero would never reach terminal count; treat it as divide-by-one.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v == {WIDTH{1'b0}}) begin
      r = WIDTH'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [WIDTH-1:0] wval_s;
  assign wval_s = clamp_div(div_wdata);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] shadow_r;
    logic             out_r;
    logic             pend_r;
    logic             term_s;

    // Terminal count marks the last clock of the current period.
    assign term_s = (cnt_r == (active_r - WIDTH'(1)));

    // Per-channel counter, output and shadow/active divisor handling.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_r    <= {WIDTH{1'b0}};
        active_r <= DEF_DIV_W;
        shadow_r <= DEF_DIV_W;
        out_r    <= 1'b0;
        pend_r   <= 1'b0;
      end else if (sync_clr || !en[i]) begin
        // Phase-align clear or disabled channel: restart from zero. Only a
        // disabled channel may adopt the shadow divisor here, since an enabled
        // channel's period boundary is defined by its own terminal count.
        cnt_r <= {WIDTH{1'b0}};
        out_r <= 1'b0;
        if (!en[i] && pend_r) begin
          active_r <= shadow_r;
        end else begin
          active_r <= active_r;
        end
        if (div_wr[i]) begin
          shadow_r <= wval_s;
          pend_r   <= 1'b1;
        end else if (!en[i]) begin
          pend_r   <= 1'b0;
        end else begin
          pend_r   <= pend_r;
        end
      end else if (term_s) begin
        // Period boundary: emit the tick / toggle and adopt any new divisor.
        cnt_r <= {WIDTH{1'b0}};
        if (mode[i]) begin
          out_r <= ~out_r;
        end else begin
          out_r <= 1'b1;
        end
        if (div_wr[i]) begin
          // A write on the boundary itself is taken straight into the active divisor.
          active_r <= wval_s;
          shadow_r <= wval_s;
          pend_r   <= 1'b0;
        end else if (pend_r) begin
          active_r <= shadow_r;
          pend_r   <= 1'b0;
        end else begin
          pend_r   <= 1'b0;
        end
      end else begin
        // Mid-period: count, and hold the square level or drop the tick.
        cnt_r <= cnt_r + WIDTH'(1);
        if (mode[i]) begin
          out_r <= out_r;
        end else begin
          out_r <= 1'b0;
        end
        if (div_wr[i]) begin
          shadow_r <= wval_s;
          pend_r   <= 1'b1;
        end else begin
          pend_r   <= pend_r;
        end
      end
    end

    assign div_out[i]  = out_r;
    assign div_pend[i] = pend_r;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi with NCH=2, WIDTH=14, DEF_DIV=12500.
module tb_clk_div_multi;

  logic        clk;
  logic        rstn;
  logic [1:0]  en;
  logic [1:0]  mode;
  logic        sync_clr;
  logic [1:0]  div_wr;
  logic [13:0] div_wdata;
  logic [1:0]  div_out;
  logic [1:0]  div_pend;

  int tests;
  int fails;

  clk_div_multi #(.NCH(2), .WIDTH(14), .DEF_DIV(12500)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .mode      (mode),
    .sync_clr  (sync_clr),
    .div_wr    (div_wr),
    .div_wdata (div_wdata),
    .div_out   (div_out),
    .div_pend  (div_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  en;
    logic [1:0]  mode;
    logic        clr;
    logic [1:0]  wr;
    logic [13:0] wd;
    logic [1:0]  out;
    logic [1:0]  pend;
  } vec_t;

  vec_t tbl[18];

  // Advance one rising edge and sample 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] e, input logic [1:0] m, input logic c,
                       input logic [1:0] w, input logic [13:0] d);
    en = e; mode = m; sync_clr = c; div_wr = w; div_wdata = d;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    int pulses, p1, p2, f0, f1;
    logic hi1;
    tests = 0;
    fails = 0;

    // Stimulus table: tick N=4 programmed while disabled, write 3 on the
    // terminal edge, write 0 (clamped to 1), write 1 on terminal, then square N=1.
    tbl[0]  = '{2'b00, 2'b00, 1'b0, 2'b01, 14'd4, 2'b00, 2'b01};
    tbl[1]  = '{2'b00, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[2]  = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[3]  = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[4]  = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[5]  = '{2'b01, 2'b00, 1'b0, 2'b01, 14'd3, 2'b01, 2'b00};
    tbl[6]  = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[7]  = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[8]  = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b01, 2'b00};
    tbl[9]  = '{2'b01, 2'b00, 1'b0, 2'b01, 14'd0, 2'b00, 2'b01};
    tbl[10] = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b00, 2'b01};
    tbl[11] = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b01, 2'b00};
    tbl[12] = '{2'b01, 2'b00, 1'b0, 2'b01, 14'd1, 2'b01, 2'b00};
    tbl[13] = '{2'b01, 2'b00, 1'b0, 2'b00, 14'd0, 2'b01, 2'b00};
    tbl[14] = '{2'b01, 2'b01, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[15] = '{2'b01, 2'b01, 1'b0, 2'b00, 14'd0, 2'b01, 2'b00};
    tbl[16] = '{2'b01, 2'b01, 1'b0, 2'b00, 14'd0, 2'b00, 2'b00};
    tbl[17] = '{2'b01, 2'b01, 1'b0, 2'b00, 14'd0, 2'b01, 2'b00};

    // Reset state
    rstn = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 2'b00, 14'd0);
    cyc();
    cyc();
    check("reset", {div_out, div_pend}, 4'b0000);
    rstn = 1'b1;

    // Test 1: default N=12500 tick on ch0, ch1 disabled
    drive(2'b01, 2'b00, 1'b0, 2'b00, 14'd0);
    pulses = 0; p1 = 0; p2 = 0; hi1 = 1'b0;
    for (int k = 1; k <= 25001; k++) begin
      cyc();
      if (div_out[0]) begin
        pulses++;
        if (pulses == 1) p1 = k;
        if (pulses == 2) p2 = k;
      end
      if (div_out[1]) hi1 = 1'b1;
    end
    check("t1_first_pulse", p1, 12500);
    check("t1_second_pulse", p2, 25000);
    check("t1_pulse_count", pulses, 2);
    check("t1_ch1_quiet", hi1, 1'b0);

    // Tests 3/4: table-driven
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].clr, tbl[i].wr, tbl[i].wd);
      cyc();
      check($sformatf("tbl%0d", i), {div_out, div_pend}, {tbl[i].out, tbl[i].pend});
    end

    // Test 2: square N=3, mid-period writes 4 then 6, then square->tick switch
    drive(2'b00, 2'b00, 1'b0, 2'b01, 14'd3);
    cyc();
    drive(2'b00, 2'b00, 1'b0, 2'b00, 14'd0);
    cyc();
    check("t2_prog", {div_out, div_pend}, 4'b0000);
    for (int e = 1; e <= 14; e++) begin
      logic o, p;
      drive(2'b01, (e == 14) ? 2'b00 : 2'b01, 1'b0,
            (e == 4 || e == 5) ? 2'b01 : 2'b00, (e == 4) ? 14'd4 : 14'd6);
      cyc();
      o = (e >= 3 && e <= 5) || (e >= 12 && e <= 13);
      p = (e == 4 || e == 5);
      check($sformatf("t2_e%0d", e), {div_out[0], div_pend[0]}, {o, p});
    end

    // Test 5: ch0 N=5, ch1 N=7, sync_clr alignment
    drive(2'b00, 2'b00, 1'b0, 2'b01, 14'd5);
    cyc();
    drive(2'b00, 2'b00, 1'b0, 2'b10, 14'd7);
    cyc();
    check("t5_pend_ch1", div_pend, 2'b10);
    drive(2'b00, 2'b00, 1'b0, 2'b00, 14'd0);
    cyc();
    check("t5_pend_clear", div_pend, 2'b00);
    drive(2'b11, 2'b00, 1'b0, 2'b00, 14'd0);
    cyc(); cyc(); cyc();
    drive(2'b11, 2'b00, 1'b1, 2'b00, 14'd0);
    cyc();
    check("t5_clr", div_out, 2'b00);
    drive(2'b11, 2'b00, 1'b0, 2'b00, 14'd0);
    for (int k = 1; k <= 8; k++) begin
      logic [1:0] x;
      cyc();
      x = {(k == 7), (k == 5)};
      check($sformatf("t5_k%0d", k), div_out, x);
    end

    // Test 6: pending write then en[0] drop, then async reset mid-count
    drive(2'b11, 2'b00, 1'b0, 2'b01, 14'd2);
    cyc();
    check("t6_pend_set", {div_out, div_pend}, 4'b0001);
    drive(2'b10, 2'b00, 1'b0, 2'b00, 14'd0);
    cyc();
    check("t6_en_drop", {div_out[0], div_pend}, 3'b000);
    drive(2'b11, 2'b00, 1'b0, 2'b00, 14'd0);
    cyc();
    check("t6_n2_e1", div_out[0], 1'b0);
    cyc();
    check("t6_n2_e2", div_out[0], 1'b1);
    drive(2'b11, 2'b00, 1'b0, 2'b01, 14'd9);
    cyc();
    check("t6_pend_again", div_pend, 2'b01);
    drive(2'b11, 2'b00, 1'b0, 2'b00, 14'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_async_rst", {div_out, div_pend}, 4'b0000);
    drive(2'b00, 2'b00, 1'b0, 2'b00, 14'd0);
    #2;
    rstn = 1'b1;
    drive(2'b11, 2'b00, 1'b0, 2'b00, 14'd0);
    f0 = 0; f1 = 0;
    for (int k = 1; k <= 12501; k++) begin
      cyc();
      if (div_out[0] && f0 == 0) f0 = k;
      if (div_out[1] && f1 == 0) f1 = k;
    end
    check("t6_ch0_default", f0, 12500);
    check("t6_ch1_default", f1, 12500);
    check("t6_pend_lost", div_pend, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
